param_lfsr: RTL
===============

PARAM_LFSR -- requirements
Module: param_lfsr

Interface
REQ-001 Parameter WIDTH, default 64: state width in bits, legal range 2..64.
REQ-002 Parameter TAPS, default 64'h0000_0000_8000_2101: feedback tap mask; bit i set means state bit i participates.
REQ-003 Parameter MODE, default 0: 0 = Fibonacci, 1 = Galois.
REQ-004 Parameter INVERT, default 1: 1 = XNOR feedback, 0 = XOR; INVERT=1 with MODE=1 is illegal and SHALL fail elaboration.
REQ-005 Parameter SEED, default 0: reset and recovery state; SHALL not equal the lockup value, otherwise fail elaboration.
REQ-006 Parameter CNT_W, default 16: width of the step counter and period register.
REQ-007 CLK  input  1  clock; all state changes on rising edge.
REQ-008 RST  input  1  synchronous, active-high reset.
REQ-009 EN  input  1  advance the LFSR one step this cycle.
REQ-010 LOAD  input  1  load SEED_IN into state this cycle.
REQ-011 SEED_IN  input  WIDTH  runtime seed value.
REQ-012 OUT  output  WIDTH  current state, registered.
REQ-013 SOUT  output  1  serial output, equal to OUT[0].
REQ-014 LOCKUP  output  1  high while state equals the lockup value: all-zeros if INVERT=0, all-ones if INVERT=1.
REQ-015 WRAP  output  1  registered one-cycle pulse on sequence return to reference seed.
REQ-016 COUNT  output  CNT_W  steps taken since last reset/load/wrap.
REQ-017 PERIOD  output  CNT_W  length of the most recently completed cycle.

Function
REQ-018 Priority per cycle SHALL be RST > LOAD > EN; with none asserted, all registers hold.
REQ-019 Fibonacci step: next = {fb, state[WIDTH-1:1]}, fb = XOR of state bits selected by TAPS, inverted if INVERT=1.
REQ-020 Galois step: next[WIDTH-1] = state[0]; next[i] = state[i+1] ^ (TAPS[i] & state[0]) for i < WIDTH-1.
REQ-021 LOAD: state <= SEED_IN, reference seed <= SEED_IN, COUNT <= 0, WRAP <= 0; PERIOD holds.
REQ-022 EN step: COUNT increments modulo 2^CNT_W; if next state equals reference seed then WRAP <= 1, PERIOD <= COUNT+1 (truncated to CNT_W), COUNT <= 0.
REQ-023 WRAP SHALL be 0 in every cycle not immediately following a qualifying step.
REQ-024 LOCKUP SHALL be combinational from state, with no added latency.
REQ-025 LOAD of a lockup value SHALL be accepted; LOCKUP asserts the next cycle.
REQ-026 COUNT overflow SHALL wrap silently to 0 and not affect WRAP.

Reset
REQ-027 On RST: state <= SEED, reference seed <= SEED, COUNT <= 0, PERIOD <= 0, WRAP <= 0.
REQ-028 RST asserted mid-sequence or together with LOAD/EN SHALL take effect on that edge and discard the other inputs.

Configuration
REQ-029 Macro PARAM_LFSR_LOCKUP_RECOVER_EN defined: an EN step taken while LOCKUP=1 SHALL load SEED into state and reference seed, clear COUNT, keep WRAP=0, and keep PERIOD.
REQ-030 Macro undefined: an EN step while LOCKUP=1 follows REQ-019/020 unchanged, so state stays stuck and LOCKUP stays high until LOAD or RST.

Verification
REQ-031 Default params, RST then 3 EN cycles -> OUT = 64'hE000_0000_0000_0000, COUNT = 3, LOCKUP = 0.
REQ-032 WIDTH=4, TAPS=4'b0011, MODE=0, INVERT=0, LOAD SEED_IN=4'b0001, then EN x15 -> OUT sequence 1000, 0100, 0010, 1001 ... 0001; WRAP pulses once after the 15th step; PERIOD = 15; COUNT = 0.
REQ-033 WIDTH=4, TAPS=4'b0100, MODE=1, INVERT=0, LOAD 4'b0001, EN x1 -> OUT = 4'b1100, SOUT = 0.
REQ-034 REQ-032 config, LOAD 4'b0000, then EN -> LOCKUP = 1; with macro OUT = SEED next cycle and LOCKUP = 0; without macro OUT stays 0000 and LOCKUP = 1.
REQ-035 REQ-032 config, mid-sequence assert LOAD and EN together with SEED_IN=4'b1010 -> OUT = 1010 and COUNT = 0; RST, LOAD and EN together -> OUT = SEED and PERIOD = 0.

Source files
------------

// File: rtl/param_lfsr.sv
// param_lfsr: parameterised Fibonacci/Galois LFSR with step counter, wrap detection and period capture.
// Define PARAM_LFSR_LOCKUP_RECOVER_EN to reseed from SEED when stepping while in the lockup state.
module param_lfsr #(
    parameter int          WIDTH  = 64,
    parameter logic [63:0] TAPS   = 64'h0000_0000_8000_2101,
    parameter int          MODE   = 0,
    parameter int          INVERT = 1,
    parameter logic [63:0] SEED   = 64'h0,
    parameter int          CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED_IN,
    output logic [WIDTH-1:0] OUT,
    output logic             SOUT,
    output logic             LOCKUP,
    output logic             WRAP,
    output logic [CNT_W-1:0] COUNT,
    output logic [CNT_W-1:0] PERIOD
);
    localparam logic [WIDTH-1:0] TAP_M  = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_V = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LOCK_V = {WIDTH{INVERT == 1}};
`ifdef PARAM_LFSR_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("param_lfsr: WIDTH must be in 2..64");
    end
    if (MODE == 1 && INVERT == 1) begin : g_bad_mode
        $error("param_lfsr: XNOR feedback is not supported in Galois mode");
    end
    if (SEED_V == LOCK_V) begin : g_bad_seed
        $error("param_lfsr: SEED equals the lockup value");
    end

    logic [WIDTH-1:0] state_q, state_d, ref_q, ref_d, nxt;
    logic [CNT_W-1:0] count_q, count_d, period_q, period_d;
    logic             wrap_q, wrap_d, fb, lockup;

    assign lockup = state_q == LOCK_V;

    always_comb begin
        fb       = ^(state_q & TAP_M) ^ (INVERT == 1);
        nxt      = (MODE == 1) ? {state_q[0], state_q[WIDTH-1:1] ^ (TAP_M[WIDTH-2:0] & {(WIDTH-1){state_q[0]}})}
                               : {fb, state_q[WIDTH-1:1]};
        state_d  = state_q;
        ref_d    = ref_q;
        count_d  = count_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (LOAD) begin
            state_d = SEED_IN;
            ref_d   = SEED_IN;
            count_d = '0;
        end else if (EN && RECOVER && lockup) begin
            state_d = SEED_V;
            ref_d   = SEED_V;
            count_d = '0;
        end else if (EN) begin
            state_d = nxt;
            count_d = count_q + 1'b1;
            // Returning to the reference seed closes a cycle; COUNT overflow alone never does.
            if (nxt == ref_q) begin
                wrap_d   = 1'b1;
                period_d = count_q + 1'b1;
                count_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= SEED_V;
            ref_q    <= SEED_V;
            count_q  <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            count_q  <= count_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign OUT    = state_q;
    assign SOUT   = state_q[0];
    assign LOCKUP = lockup;
    assign WRAP   = wrap_q;
    assign COUNT  = count_q;
    assign PERIOD = period_q;
endmodule
